// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared constants and types for the FIR tap sequencer slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 12;
    localparam int EXPT_W = 3;
    localparam int CBS_W  = 3;

    localparam logic [CBS_W-1:0] CBS_SAMPLE = 3'd0;
    localparam logic [CBS_W-1:0] CBS_COEF   = 3'd1;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CFG   = 3'd1;
    localparam logic [ST_W-1:0] ST_ISX   = 3'd2;
    localparam logic [ST_W-1:0] ST_ISH   = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

    // Kind of dag read issued in a given cycle, carried down the strobe pipe.
    typedef struct packed {
        logic is_x;
        logic is_h;
        logic first;
    } rd_kind_t;

endpackage

`default_nettype wire

// File: rtl/fir_strobe_pipe.sv
// ============================================================================
// Module   : fir_strobe_pipe
// Purpose  : L-deep delay of read kinds; emits operand loads and MAC strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_strobe_pipe
    import fir_pkg::*;
#(
    parameter int L = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rd_kind_t kind,
    output logic     x_ld,
    output logic     h_ld,
    output logic     mac_en,
    output logic     mac_clr
);

    rd_kind_t r_stage [L];
    logic     r_mac_en;
    logic     r_mac_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                r_stage[i] <= '0;
            end
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
        end else begin
            r_stage[0] <= kind;
            for (int i = 1; i < L; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            // Both operands are loaded once the coefficient lands, so MAC follows h_ld.
            r_mac_en  <= r_stage[L-1].is_h;
            r_mac_clr <= r_stage[L-1].is_h & r_stage[L-1].first;
        end
    end

    assign x_ld    = r_stage[L-1].is_x;
    assign h_ld    = r_stage[L-1].is_h;
    assign mac_en  = r_mac_en;
    assign mac_clr = r_mac_clr;

endmodule

`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
// ============================================================================
// Module   : fir_tap_sequencer
// Purpose  : Programs dag buffers and issues interleaved x/h reads per sample.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS   = 8,
    parameter int DAG_LAT = 1,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [EXPT_W-1:0] cfg_expt,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              dag_re,
    output logic [CBS_W-1:0]  dag_cbs,
    output logic              dag_we,
    output logic [ADDR_W-1:0] dag_base,
    output logic [LEN_W-1:0]  dag_len,
    output logic              dag_sign,
    output logic [EXPT_W-1:0] dag_expt,
    output logic              x_ld,
    output logic              h_ld,
    output logic              mac_en,
    output logic              mac_clr
);

    localparam int c_lat        = DAG_LAT + MEM_LAT;
    localparam int c_tap_w      = $clog2(NTAPS + 1);
    localparam int c_drain_w    = $clog2(c_lat + 2);
    localparam logic [c_tap_w-1:0]   c_last_tap   = c_tap_w'(NTAPS - 1);
    localparam logic [c_drain_w-1:0] c_drain_init = c_drain_w'(c_lat + 1);

    logic [ST_W-1:0]      r_state;
    logic [c_tap_w-1:0]   r_tap_cnt;
    logic [c_drain_w-1:0] r_drain_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_cfg_err;
    logic                 r_dag_re;
    logic [CBS_W-1:0]     r_dag_cbs;
    logic                 r_dag_we;
    logic [ADDR_W-1:0]    r_dag_base;
    logic [LEN_W-1:0]     r_dag_len;
    logic [EXPT_W-1:0]    r_dag_expt;
    rd_kind_t             w_kind;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_dag_re    <= 1'b0;
            r_dag_cbs   <= '0;
            r_dag_we    <= 1'b0;
            r_dag_base  <= '0;
            r_dag_len   <= '0;
            r_dag_expt  <= '0;
        end else begin
            r_dag_we  <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= cfg_we && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    // Configuration takes priority; a simultaneous start is dropped.
                    if (cfg_we) begin
                        r_state    <= ST_CFG;
                        r_dag_we   <= 1'b1;
                        r_dag_cbs  <= {2'b00, cfg_sel};
                        r_dag_base <= cfg_base;
                        r_dag_len  <= cfg_len;
                        r_dag_expt <= cfg_expt;
                    end else if (start) begin
                        r_state   <= ST_ISX;
                        r_busy    <= 1'b1;
                        r_dag_re  <= 1'b1;
                        r_dag_cbs <= CBS_SAMPLE;
                        r_tap_cnt <= '0;
                    end
                end
                ST_CFG: begin
                    r_state    <= ST_IDLE;
                    r_dag_cbs  <= '0;
                    r_dag_base <= '0;
                    r_dag_len  <= '0;
                    r_dag_expt <= '0;
                end
                ST_ISX: begin
                    r_state   <= ST_ISH;
                    r_dag_cbs <= CBS_COEF;
                end
                ST_ISH: begin
                    r_tap_cnt <= r_tap_cnt + 1'b1;
                    r_dag_cbs <= CBS_SAMPLE;
                    if (r_tap_cnt == c_last_tap) begin
                        r_state     <= ST_DRAIN;
                        r_dag_re    <= 1'b0;
                        r_drain_cnt <= c_drain_init;
                    end else begin
                        r_state <= ST_ISX;
                    end
                end
                ST_DRAIN: begin
                    // Counter covers the strobe latency plus the trailing MAC cycle.
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_done      <= (r_drain_cnt == c_drain_w'(1));
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_kind       = '0;
        w_kind.is_x  = (r_state == ST_ISX);
        w_kind.is_h  = (r_state == ST_ISH);
        w_kind.first = (r_tap_cnt == '0);
    end

    fir_strobe_pipe #(
        .L (c_lat)
    ) u_strobe_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .kind    (w_kind),
        .x_ld    (x_ld),
        .h_ld    (h_ld),
        .mac_en  (mac_en),
        .mac_clr (mac_clr)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign cfg_err  = r_cfg_err;
    assign dag_re   = r_dag_re;
    assign dag_cbs  = r_dag_cbs;
    assign dag_we   = r_dag_we;
    assign dag_base = r_dag_base;
    assign dag_len  = r_dag_len;
    assign dag_sign = 1'b0;
    assign dag_expt = r_dag_expt;

endmodule

`default_nettype wire
